tinker_fetch: RTL and testbench

Instruction fetch stage for the Tinker core. It holds the program counter, issues in-order 32-bit instruction reads to instruction memory through a valid/ready request port, buffers returned words in a small prefetch FIFO, and presents them with their PC on a valid/ready port that drives the `instruction` input of `tinker_core`. Control-flow redirects from the core flush the buffer, discard stale in-flight responses, and restart fetch at the target PC.

---
 rtl/tinker_pkg.sv | 29 ++
 rtl/tinker_fetch_if.sv | 31 +++
 rtl/tinker_fetch_fifo.sv | 56 +++++
 rtl/tinker_fetch.sv | 122 ++++++++++++
 tb/tb_tinker_fetch.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/tinker_pkg.sv
// rtl/tinker_pkg.sv - shared Tinker widths, instruction fields and fetch state type
package tinker_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int L_HI   = 11;
  localparam int L_LO   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  function automatic logic [OPC_HI-OPC_LO:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/tinker_fetch_if.sv
// rtl/tinker_fetch_if.sv - memory request/response, instruction and redirect signals of the fetch stage
interface tinker_fetch_if;
  import tinker_pkg::*;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_resp_valid;
  logic [INSTR_W-1:0] mem_resp_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  instr_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  // Fetch stage side
  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instruction, instr_pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  // Memory and core side
  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instruction, instr_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/tinker_fetch_fifo.sv
// rtl/tinker_fetch_fifo.sv - circular FIFO with synchronous flush, count, full and empty
module tinker_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [AW:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer, count and storage update; flush discards everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/tinker_fetch.sv
// rtl/tinker_fetch.sv - Tinker instruction fetch: PC, request issue, prefetch buffer, redirect flush
module tinker_fetch
  import tinker_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h2000,
  parameter int                DEPTH    = 4
) (
  input logic            clk,
  input logic            reset_n,
  tinker_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_W + ADDR_W;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     stale_q, stale_d;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     data_count, tag_count;
  logic              data_full, data_empty, tag_full, tag_empty;
  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] tag_head;
  logic [CW:0]       occupancy;
  logic              req_valid, req_fire, resp_stale, resp_good, redir, pop;

  // Buffered plus in-flight words never exceed the FIFO size, so responses always fit
  assign occupancy  = {1'b0, data_count} + {1'b0, outst_q};
  assign req_valid  = (state_q == RUN) && (occupancy < DEPTH_C);
  assign req_fire   = req_valid && bus.mem_req_ready;
  assign redir      = bus.redirect_valid && (state_q != IDLE);
  assign resp_stale = bus.mem_resp_valid && (stale_q != '0);
  assign resp_good  = bus.mem_resp_valid && (stale_q == '0) && (outst_q != '0);
  assign pop        = !data_empty && bus.instr_ready;

  // Words still owed by memory after this cycle, including a request accepted now
  assign inflight = stale_q + outst_q + CW'(req_fire) - CW'(resp_stale || resp_good);

  // Next-state: redirect overrides everything else happening in the same cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    outst_d = outst_q + CW'(req_fire) - CW'(resp_good);
    stale_d = stale_q - CW'(resp_stale);
    if (req_fire) pc_d = pc_q + 64'd4;
    case (state_q)
      IDLE:    state_d = RUN;
      FLUSH:   if (stale_d == '0) state_d = RUN;
      default: state_d = state_q;
    endcase
    if (redir) begin
      pc_d    = bus.redirect_pc & ~ADDR_W'(3);
      outst_d = '0;
      stale_d = inflight;
      state_d = (inflight != '0) ? FLUSH : RUN;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      stale_q <= stale_d;
    end
  end

  tinker_fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_data_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .flush_i (redir),
    .push_i  (resp_good && !redir),
    .data_i  ({bus.mem_resp_data, tag_head}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (data_count),
    .full_o  (data_full),
    .empty_o (data_empty)
  );

  tinker_fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .flush_i (redir),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (resp_good),
    .data_o  (tag_head),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = pc_q;
  assign bus.instr_valid   = !data_empty;
  // Outputs read zero while empty so a flushed word never shows on the core port
  assign bus.instruction   = data_empty ? '0 : head[EW-1 -: INSTR_W];
  assign bus.instr_pc      = data_empty ? '0 : head[ADDR_W-1:0];

`ifndef SYNTHESIS
  // Flag responses with nothing in flight and tag queue drifting from the outstanding count
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(bus.mem_resp_valid && stale_q == '0 && outst_q == '0))
        else $error("tinker_fetch: response with no request in flight");
      assert ((tag_count == outst_q) && (tag_empty == (outst_q == '0)) &&
              !(data_full && outst_q != '0) && !(tag_full && data_count != '0))
        else $error("tinker_fetch: in-flight bookkeeping out of step");
    end
  end
`endif

endmodule

// File: tb/tb_tinker_fetch.sv
// tb/tb_tinker_fetch.sv - directed bench for tinker_fetch
module tb_tinker_fetch;
  import tinker_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tinker_fetch_if bus();

  tinker_fetch #(.RESET_PC(64'h2000), .DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  int fire_cnt = 0;
  int f0 = 0;
  logic [63:0] last_fire = '0;
  logic [63:0] q_addr[$];
  int          q_due[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hC100_0000 | {20'h0, a[11:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tickn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int l, input logic rdy);
    reset_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_req_ready = 1'b1;
    bus.instr_ready = rdy;
    lat = l;
    tickn(2);
    reset_n = 1'b1;
    f0 = fire_cnt;
  endtask

  // Fixed-latency in-order memory: responses driven after posedge, requests sampled mid-cycle
  initial begin
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.mem_resp_valid = 1'b0;
      if (reset_n && q_due.size() > 0 && q_due[0] == cyc) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      @(negedge clk);
      #2;
      if (!reset_n) begin
        q_addr.delete();
        q_due.delete();
      end else if (bus.mem_req_valid && bus.mem_req_ready) begin
        q_addr.push_back(bus.mem_req_addr);
        q_due.push_back(cyc + lat);
        fire_cnt++;
        last_fire = bus.mem_req_addr;
      end
    end
  end

  initial begin
    bus.mem_req_ready = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    reset_n = 1'b0;
    tickn(2);
    chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_instruction", 64'(bus.instruction), 64'd0);
    chk("rst_instr_pc", bus.instr_pc, 64'd0);

    // Reset and first fetch
    do_reset(1, 1'b1);
    chk("idle_no_req", 64'(bus.mem_req_valid), 64'd0);
    tickn(1);
    chk("first_req_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("first_req_addr", bus.mem_req_addr, 64'h2000);
    chk("first_instr_not_yet", 64'(bus.instr_valid), 64'd0);
    tickn(1);
    chk("second_req_addr", bus.mem_req_addr, 64'h2004);
    chk("no_bypass", 64'(bus.instr_valid), 64'd0);
    tickn(1);
    chk("first_instr_valid", 64'(bus.instr_valid), 64'd1);
    chk("first_instr_pc", bus.instr_pc, 64'h2000);
    chk("first_instruction", 64'(bus.instruction), 64'hC100_0000);
    for (int k = 1; k <= 4; k++) begin
      tickn(1);
      chk("stream_valid", 64'(bus.instr_valid), 64'd1);
      chk("stream_pc", bus.instr_pc, 64'h2000 + 64'(4 * k));
      chk("stream_word", 64'(bus.instruction), 64'(mem_word(64'h2000 + 64'(4 * k))));
    end

    // Back-pressure
    do_reset(1, 1'b0);
    tickn(10);
    chk("bp_four_requests", 64'(fire_cnt - f0), 64'd4);
    chk("bp_req_stopped", 64'(bus.mem_req_valid), 64'd0);
    chk("bp_head_pc", bus.instr_pc, 64'h2000);
    bus.instr_ready = 1'b1;
    tickn(1);
    bus.instr_ready = 1'b0;
    chk("bp_head_after_pop", bus.instr_pc, 64'h2004);
    chk("bp_new_req_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("bp_new_req_addr", bus.mem_req_addr, 64'h2010);
    tickn(6);
    chk("bp_one_more_request", 64'(fire_cnt - f0), 64'd5);
    chk("bp_last_addr", last_fire, 64'h2010);
    chk("bp_req_stopped_again", 64'(bus.mem_req_valid), 64'd0);

    // Redirect with three responses in flight
    do_reset(3, 1'b1);
    tickn(3);
    chk("rd_third_req", 64'(bus.mem_req_valid), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h3002;
    tickn(1);
    bus.redirect_valid = 1'b0;
    chk("rd_flush_instr_valid", 64'(bus.instr_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk("rd_no_req_while_stale", 64'(bus.mem_req_valid), 64'd0);
      tickn(1);
    end
    chk("rd_restart_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("rd_restart_addr", bus.mem_req_addr, 64'h3000);
    chk("rd_fire_count", 64'(fire_cnt - f0), 64'd3);
    for (int k = 0; k < 3; k++) begin
      tickn(1);
      chk("rd_no_stale_word", 64'(bus.instr_valid), 64'd0);
    end
    tickn(1);
    chk("rd_new_valid", 64'(bus.instr_valid), 64'd1);
    chk("rd_new_pc", bus.instr_pc, 64'h3000);
    chk("rd_new_word", 64'(bus.instruction), 64'(mem_word(64'h3000)));

    // Redirect colliding with a response and a pop
    do_reset(1, 1'b1);
    tickn(3);
    chk("col_head_present", 64'(bus.instr_valid), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h4000;
    tickn(1);
    bus.redirect_valid = 1'b0;
    chk("col_fifo_empty", 64'(bus.instr_valid), 64'd0);
    chk("col_instruction_clear", 64'(bus.instruction), 64'd0);
    chk("col_no_req", 64'(bus.mem_req_valid), 64'd0);
    tickn(1);
    chk("col_restart_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("col_restart_addr", bus.mem_req_addr, 64'h4000);
    chk("col_still_empty", 64'(bus.instr_valid), 64'd0);
    tickn(1);
    chk("col_still_empty2", 64'(bus.instr_valid), 64'd0);
    tickn(1);
    chk("col_new_valid", 64'(bus.instr_valid), 64'd1);
    chk("col_new_pc", bus.instr_pc, 64'h4000);
    chk("col_new_word", 64'(bus.instruction), 64'(mem_word(64'h4000)));

    // PC wrap
    do_reset(1, 1'b1);
    tickn(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tickn(1);
    bus.redirect_valid = 1'b0;
    chk("wrap_flush_no_req", 64'(bus.mem_req_valid), 64'd0);
    tickn(1);
    chk("wrap_addr_top", bus.mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_req_valid", 64'(bus.mem_req_valid), 64'd1);
    tickn(1);
    chk("wrap_addr_zero", bus.mem_req_addr, 64'h0);
    tickn(1);
    chk("wrap_instr_pc_top", bus.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_word_top", 64'(bus.instruction), 64'hC100_0FFC);
    tickn(1);
    chk("wrap_instr_pc_zero", bus.instr_pc, 64'h0);
    chk("wrap_word_zero", 64'(bus.instruction), 64'hC100_0000);

    // Asynchronous reset with a full FIFO
    do_reset(1, 1'b0);
    tickn(8);
    chk("full_head_valid", 64'(bus.instr_valid), 64'd1);
    chk("full_no_req", 64'(bus.mem_req_valid), 64'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("async_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("async_instr_pc", bus.instr_pc, 64'd0);
    tickn(1);
    reset_n = 1'b1;
    bus.instr_ready = 1'b1;
    tickn(1);
    chk("restart_req_addr", bus.mem_req_addr, 64'h2000);
    chk("restart_req_valid", 64'(bus.mem_req_valid), 64'd1);
    tickn(2);
    chk("restart_instr_valid", 64'(bus.instr_valid), 64'd1);
    chk("restart_instr_pc", bus.instr_pc, 64'h2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
